// File: rtl/pipeline_sequencer.sv
// ============================================================================
//  Module   : pipeline_sequencer
//  Purpose  : Run controller for the 5-stage MIPS pipeline. Starts execution,
//             selects free-run or single-step, detects END/FINISH opcodes in
//             decode, drains the in-flight instructions and reports done.
//  Options  : SEQ_WATCHDOG_EN - adds WDOG_LIMIT and the timeout output; a RUN
//             phase lasting WDOG_LIMIT cycles without a halt opcode is
//             forced into DRAIN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer #(
   parameter int unsigned CYCLE_W      = 32,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter logic [5:0]  OP_END       = 6'b111111,
   parameter logic [5:0]  OP_FINISH    = 6'b111110
`ifdef SEQ_WATCHDOG_EN
   ,parameter int unsigned WDOG_LIMIT  = 1_000_000
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               step_mode,
   input  logic               step,
   input  logic [5:0]         OpD,
   input  logic               stall,
   output logic               pc_en,
   output logic               pipe_en,
   output logic               inicio,
   output logic               running,
   output logic               done,
   output logic [CYCLE_W-1:0] cycle_count
`ifdef SEQ_WATCHDOG_EN
   ,output logic              timeout
`endif
);

   localparam int unsigned        DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0]   DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
   localparam logic [CYCLE_W-1:0] CNT_MAX  = {CYCLE_W{1'b1}};

`ifdef SEQ_WATCHDOG_EN
   localparam int unsigned        WD_W     = $clog2(WDOG_LIMIT + 1);
   localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(WDOG_LIMIT - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RUN       = 3'd1,
      S_STEP_WAIT = 3'd2,
      S_STEP_EXEC = 3'd3,
      S_DRAIN     = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CYCLE_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [DRN_W-1:0]     drain_q, drain_d;
   logic                 step_q;
   logic                 pipe_en_q, inicio_q, running_q, done_q;
   logic                 halt_op, step_pulse;

`ifdef SEQ_WATCHDOG_EN
   logic [WD_W-1:0]      wdog_q, wdog_d;
   logic                 timeout_q, timeout_d;
`endif

   assign halt_op    = (OpD == OP_END) || (OpD == OP_FINISH);
   assign step_pulse = step && !step_q;
   assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // PC advances only in executing states, and never past a halt or a stall
   assign pc_en = ((state_q == S_RUN) || (state_q == S_STEP_EXEC)) && !stall && !halt_op;

   // Next-state, cycle counter, drain counter and watchdog decisions
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
`ifdef SEQ_WATCHDOG_EN
      wdog_d    = '0;
      timeout_d = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = step_mode ? S_STEP_WAIT : S_RUN;
`ifdef SEQ_WATCHDOG_EN
               timeout_d = 1'b0;
`endif
            end
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            if (halt_op && !stall) begin
               state_d = S_DRAIN;
               drain_d = DRN_LOAD;
            end
`ifdef SEQ_WATCHDOG_EN
            else if (!halt_op) begin
               if (wdog_q == WD_LAST) begin
                  state_d   = S_DRAIN;
                  drain_d   = DRN_LOAD;
                  timeout_d = 1'b1;
               end else begin
                  wdog_d = wdog_q + 1'b1;
               end
            end
`endif
         end
         S_STEP_WAIT: begin
            if (step_pulse) begin
               state_d = S_STEP_EXEC;
            end
         end
         S_STEP_EXEC: begin
            cnt_d = cnt_inc;
            if (halt_op && !stall) begin
               state_d = S_DRAIN;
               drain_d = DRN_LOAD;
            end else begin
               state_d = S_STEP_WAIT;
            end
         end
         S_DRAIN: begin
            cnt_d = cnt_inc;
            if (drain_q == '0) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         S_DONE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = S_IDLE;
`ifdef SEQ_WATCHDOG_EN
               timeout_d = 1'b0;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters, step edge register and outputs registered from next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         drain_q   <= '0;
         step_q    <= 1'b0;
         pipe_en_q <= 1'b0;
         inicio_q  <= 1'b1;
         running_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
         wdog_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         drain_q   <= drain_d;
         step_q    <= step;
         pipe_en_q <= (state_d == S_RUN) || (state_d == S_STEP_EXEC) || (state_d == S_DRAIN);
         inicio_q  <= (state_d == S_IDLE) || (state_d == S_DRAIN) || (state_d == S_DONE);
         running_q <= (state_d == S_RUN) || (state_d == S_STEP_EXEC) || (state_d == S_DRAIN);
         done_q    <= (state_d == S_DONE);
`ifdef SEQ_WATCHDOG_EN
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign pipe_en     = pipe_en_q;
   assign inicio      = inicio_q;
   assign running     = running_q;
   assign done        = done_q;
   assign cycle_count = cnt_q;
`ifdef SEQ_WATCHDOG_EN
   assign timeout     = timeout_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
//  Module   : tb_pipeline_sequencer
//  Purpose  : Self-checking bench for pipeline_sequencer (CYCLE_W = 4).
//             A reference model pushes the expected outputs of every driven
//             cycle into a queue; the monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;

   localparam logic [5:0] END_OP = 6'b111111;
   localparam logic [5:0] FIN_OP = 6'b111110;

   localparam int M_IDLE = 0, M_RUN = 1, M_SWAIT = 2, M_SEXEC = 3, M_DRAIN = 4, M_DONE = 5;

   typedef struct packed {
      logic       pc;
      logic       pe;
      logic       ini;
      logic       run;
      logic       dn;
      logic [3:0] cnt;
      logic       to;
   } exp_t;

   logic       clk, reset, start, step_mode, step, stall;
   logic [5:0] OpD;
   logic       pc_en, pipe_en, inicio, running, done;
   logic [3:0] cycle_count;
   logic       to_obs;

   int n_cmp = 0;
   int n_err = 0;

   exp_t q_exp[$];

   int         m_st, m_drain, m_wd;
   logic [3:0] m_cnt;
   logic       m_stepq, m_to;

`ifdef SEQ_WATCHDOG_EN
   pipeline_sequencer #(.CYCLE_W(4), .WDOG_LIMIT(8)) dut (
`else
   pipeline_sequencer #(.CYCLE_W(4)) dut (
`endif
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .step_mode   (step_mode),
      .step        (step),
      .OpD         (OpD),
      .stall       (stall),
      .pc_en       (pc_en),
      .pipe_en     (pipe_en),
      .inicio      (inicio),
      .running     (running),
      .done        (done),
      .cycle_count (cycle_count)
`ifdef SEQ_WATCHDOG_EN
      ,.timeout    (to_obs)
`endif
   );

`ifndef SEQ_WATCHDOG_EN
   assign to_obs = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st    = M_IDLE;
      m_cnt   = 4'd0;
      m_drain = 0;
      m_wd    = 0;
      m_stepq = 1'b0;
      m_to    = 1'b0;
   endtask

   // Reference behaviour of one clock edge
   task automatic model_step(input logic s, input logic md, input logic st,
                             input logic [5:0] op, input logic sl);
      logic halt;
      logic pulse;
      int   wd_next;
      halt    = (op == END_OP) || (op == FIN_OP);
      pulse   = st && !m_stepq;
      wd_next = 0;
      case (m_st)
         M_IDLE: if (s) begin m_cnt = 4'd0; m_to = 1'b0; m_st = md ? M_SWAIT : M_RUN; end
         M_RUN: begin
            if (m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
            if (halt && !sl) begin
               m_st = M_DRAIN; m_drain = 3;
            end
`ifdef SEQ_WATCHDOG_EN
            else if (!halt) begin
               if (m_wd + 1 == 8) begin m_st = M_DRAIN; m_drain = 3; m_to = 1'b1; end
               else wd_next = m_wd + 1;
            end
`endif
         end
         M_SWAIT: if (pulse) m_st = M_SEXEC;
         M_SEXEC: begin
            if (m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
            if (halt && !sl) begin m_st = M_DRAIN; m_drain = 3; end
            else m_st = M_SWAIT;
         end
         M_DRAIN: begin
            if (m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
            m_drain = m_drain - 1;
            if (m_drain == 0) m_st = M_DONE;
         end
         M_DONE: if (s) begin m_cnt = 4'd0; m_to = 1'b0; m_st = M_IDLE; end
         default: m_st = M_IDLE;
      endcase
      m_wd    = wd_next;
      m_stepq = st;
   endtask

   // Drive one cycle, push its expectation, compare away from the edge, advance model
   task automatic cyc(input logic s, input logic md, input logic st,
                      input logic [5:0] op, input logic sl);
      exp_t e;
      exp_t g;
      logic halt;
      @(negedge clk);
      start = s; step_mode = md; step = st; OpD = op; stall = sl;
      halt  = (op == END_OP) || (op == FIN_OP);
      e.pc  = ((m_st == M_RUN) || (m_st == M_SEXEC)) && !sl && !halt;
      e.pe  = (m_st == M_RUN) || (m_st == M_SEXEC) || (m_st == M_DRAIN);
      e.ini = (m_st == M_IDLE) || (m_st == M_DRAIN) || (m_st == M_DONE);
      e.run = (m_st == M_RUN) || (m_st == M_SEXEC) || (m_st == M_DRAIN);
      e.dn  = (m_st == M_DONE);
      e.cnt = m_cnt;
      e.to  = m_to;
      q_exp.push_back(e);
      #2;
      if (q_exp.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         g = q_exp.pop_front();
         chk("pc_en",   {31'd0, pc_en},   {31'd0, g.pc});
         chk("pipe_en", {31'd0, pipe_en}, {31'd0, g.pe});
         chk("inicio",  {31'd0, inicio},  {31'd0, g.ini});
         chk("running", {31'd0, running}, {31'd0, g.run});
         chk("done",    {31'd0, done},    {31'd0, g.dn});
         chk("count",   {28'd0, cycle_count}, {28'd0, g.cnt});
`ifdef SEQ_WATCHDOG_EN
         chk("timeout", {31'd0, to_obs},  {31'd0, g.to});
`endif
      end
      model_step(s, md, st, op, sl);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; OpD = 6'd0; stall = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #2;
      chk("rst_pc_en",   {31'd0, pc_en},   32'd0);
      chk("rst_pipe_en", {31'd0, pipe_en}, 32'd0);
      chk("rst_inicio",  {31'd0, inicio},  32'd1);
      chk("rst_running", {31'd0, running}, 32'd0);
      chk("rst_done",    {31'd0, done},    32'd0);
      chk("rst_count",   {28'd0, cycle_count}, 32'd0);
      reset = 1'b0;

      // Free run: six RUN cycles, FINISH in the sixth, then three DRAIN cycles
      cyc(1, 0, 0, 6'd0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 6'h08, 0);
      cyc(0, 0, 0, FIN_OP, 0);
      chk("fr_halt_pc_en", {31'd0, pc_en}, 32'd0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 6'd0, 0);
      cyc(0, 0, 0, 6'd0, 0);
      chk("fr_done",  {31'd0, done}, 32'd1);
      chk("fr_count", {28'd0, cycle_count}, 32'd9);
      cyc(0, 0, 0, FIN_OP, 0);
      chk("fr_frozen", {28'd0, cycle_count}, 32'd9);

      // Restart from DONE, then halt while stalled
      cyc(1, 0, 0, 6'd0, 0);
      cyc(1, 0, 0, 6'd0, 0);
      cyc(0, 0, 0, 6'd0, 0);
      cyc(0, 0, 0, END_OP, 1);
      cyc(0, 0, 0, END_OP, 1);
      chk("stall_running", {31'd0, running}, 32'd1);
      cyc(0, 0, 0, END_OP, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 6'd0, 0);
      chk("stall_done", {31'd0, done}, 32'd1);

      // Single step: start with step already high must not execute
      cyc(1, 0, 0, 6'd0, 0);
      cyc(1, 1, 1, 6'd0, 0);
      cyc(0, 0, 1, 6'd0, 0);
      cyc(0, 0, 0, 6'd0, 0);
      chk("step_simul_count", {28'd0, cycle_count}, 32'd0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 6'd0, 0);
      cyc(0, 0, 0, 6'd0, 0);
      chk("step_one_count", {28'd0, cycle_count}, 32'd1);
      cyc(0, 0, 1, 6'd0, 1);
      cyc(0, 0, 0, 6'd0, 1);
      cyc(0, 0, 0, 6'd0, 0);
      chk("step_two_count", {28'd0, cycle_count}, 32'd2);
      cyc(0, 0, 1, 6'd0, 0);
      cyc(0, 0, 0, FIN_OP, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 6'd0, 0);
      chk("step_done_count", {28'd0, cycle_count}, 32'd6);

      // Asynchronous reset in the middle of DRAIN
      cyc(1, 0, 0, 6'd0, 0);
      cyc(1, 0, 0, 6'd0, 0);
      cyc(0, 0, 0, END_OP, 0);
      cyc(0, 0, 0, 6'd0, 0);
      @(negedge clk);
      start = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("arst_pc_en",   {31'd0, pc_en},   32'd0);
      chk("arst_pipe_en", {31'd0, pipe_en}, 32'd0);
      chk("arst_inicio",  {31'd0, inicio},  32'd1);
      chk("arst_running", {31'd0, running}, 32'd0);
      chk("arst_done",    {31'd0, done},    32'd0);
      chk("arst_count",   {28'd0, cycle_count}, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

`ifndef SEQ_WATCHDOG_EN
      // Saturation of the 4-bit cycle counter
      cyc(1, 0, 0, 6'd0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 6'h11, 0);
      chk("sat_count", {28'd0, cycle_count}, 32'd15);
      cyc(0, 0, 0, END_OP, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 6'd0, 0);
      chk("sat_held", {28'd0, cycle_count}, 32'd15);
`else
      // Watchdog: eight RUN cycles without halt force DRAIN
      cyc(1, 0, 0, 6'd0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 6'h11, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 6'h11, 0);
      chk("wd_timeout", {31'd0, to_obs}, 32'd1);
      chk("wd_done",    {31'd0, done},   32'd1);
      cyc(1, 0, 0, 6'd0, 0);
      cyc(0, 0, 0, 6'd0, 0);
      chk("wd_cleared", {31'd0, to_obs}, 32'd0);
`endif

      chk("sb_drained", q_exp.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
